// File: rtl/tank_move_ctrl.sv
// tank_move_ctrl: per-tank movement and fire controller.
// Commands are sampled only on frame ticks. Position is clamped to the playfield.
// Facing, movement state and fire cooldown are tracked here.
// Optional feature macro: TANK_OBSTACLE_STOP_EN. When it is defined, the module has a
// `blocked` input that freezes position while every other update carries on.
module tank_move_ctrl #(
    parameter int          POS_W     = 10,
    parameter int          SPEED_W   = 3,
    parameter int          MAP_W     = 640,
    parameter int          MAP_H     = 480,
    parameter int          TANK_SIZE = 32,
    parameter int          INIT_X    = 304,
    parameter int          INIT_Y    = 448,
    parameter logic [1:0]  INIT_DIR  = 2'b00,
    parameter int          COOLDOWN  = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    input  logic               fire,
    input  logic [SPEED_W-1:0] speed,
`ifdef TANK_OBSTACLE_STOP_EN
    input  logic               blocked,
`endif
    output logic [POS_W-1:0]   pos_x,
    output logic [POS_W-1:0]   pos_y,
    output logic [1:0]         direction,
    output logic [1:0]         state,
    output logic               fire_pulse,
    output logic               ready
);

    localparam int              CNT_W   = $clog2(COOLDOWN + 1);
    localparam logic [POS_W:0]  MAX_X   = (POS_W + 1)'(MAP_W - TANK_SIZE);
    localparam logic [POS_W:0]  MAX_Y   = (POS_W + 1)'(MAP_H - TANK_SIZE);
    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MOVE   = 2'b01,
        RELOAD = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    state_t            state_q, state_d;
    dir_t              dir_q, dir_d;
    logic [POS_W-1:0]  pos_x_q, pos_x_d;
    logic [POS_W-1:0]  pos_y_q, pos_y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pulse_q, pulse_d;

    logic              dir_active;
    logic              hold_pos;
    logic [POS_W:0]    s_ext, x_ext, y_ext;
    logic [POS_W:0]    x_inc, x_dec, y_inc, y_dec;

`ifdef TANK_OBSTACLE_STOP_EN
    assign hold_pos = blocked;
`else
    assign hold_pos = 1'b0;
`endif

    assign dir_active = up | down | left | right;

    // One extra bit of headroom on the arithmetic, so that clamping never sees a wrapped value.
    assign s_ext = (POS_W + 1)'(speed);
    assign x_ext = {1'b0, pos_x_q};
    assign y_ext = {1'b0, pos_y_q};
    assign x_inc = x_ext + s_ext;
    assign y_inc = y_ext + s_ext;
    assign x_dec = x_ext - s_ext;
    assign y_dec = y_ext - s_ext;

    // State, position, facing and cooldown registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= dir_t'(INIT_DIR);
            pos_x_q <= POS_W'(INIT_X);
            pos_y_q <= POS_W'(INIT_Y);
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state logic: direction arbitration, clamped movement, cooldown and state.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;

        if (tick) begin
            if (up)
                dir_d = DIR_UP;
            else if (down)
                dir_d = DIR_DOWN;
            else if (left)
                dir_d = DIR_LEFT;
            else if (right)
                dir_d = DIR_RIGHT;

            if (dir_active && !hold_pos) begin
                if (up)
                    pos_y_d = (y_ext < s_ext) ? '0 : y_dec[POS_W-1:0];
                else if (down)
                    pos_y_d = (y_inc > MAX_Y) ? MAX_Y[POS_W-1:0] : y_inc[POS_W-1:0];
                else if (left)
                    pos_x_d = (x_ext < s_ext) ? '0 : x_dec[POS_W-1:0];
                else
                    pos_x_d = (x_inc > MAX_X) ? MAX_X[POS_W-1:0] : x_inc[POS_W-1:0];
            end

            // While the cooldown is running, fire is dropped rather than queued.
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (fire) begin
                cnt_d   = CD_LOAD;
                pulse_d = 1'b1;
            end

            if (cnt_d != '0)
                state_d = RELOAD;
            else if (dir_active)
                state_d = MOVE;
            else
                state_d = IDLE;
        end
    end

    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign direction  = dir_q;
    assign state      = state_q;
    assign fire_pulse = pulse_q;
    assign ready      = (cnt_q == '0);

endmodule

// File: tb/tb_tank_move_ctrl.sv
// Directed self-checking bench for tank_move_ctrl (COOLDOWN overridden to 3).
module tb_tank_move_ctrl;

    logic       clk, rst, tick, up, down, left, right, fire;
    logic [2:0] speed;
    logic [9:0] pos_x, pos_y;
    logic [1:0] direction, state;
    logic       fire_pulse, ready;
`ifdef TANK_OBSTACLE_STOP_EN
    logic       blocked;
`endif

    int checks = 0;
    int errors = 0;

    int exp_pulse [10] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    int exp_ready [10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    int exp_state [10] = '{2, 2, 2, 0, 2, 2, 2, 0, 2, 2};

    tank_move_ctrl #(.COOLDOWN(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .fire       (fire),
        .speed      (speed),
`ifdef TANK_OBSTACLE_STOP_EN
        .blocked    (blocked),
`endif
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .direction  (direction),
        .state      (state),
        .fire_pulse (fire_pulse),
        .ready      (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(posedge clk);
            #1;
            tick = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        fire = 1'b0; speed = 3'd0;
`ifdef TANK_OBSTACLE_STOP_EN
        blocked = 1'b0;
`endif
        // Asynchronous reset, applied before the first clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_pos_x", pos_x, 304);
        check("rst_pos_y", pos_y, 448);
        check("rst_dir", direction, 0);
        check("rst_state", state, 0);
        check("rst_ready", ready, 1);
        check("rst_pulse", fire_pulse, 0);
        #1 rst = 1'b0;

        // Move right by 4 for three ticks.
        speed = 3'd4; right = 1'b1;
        do_tick(3);
        check("right_pos_x", pos_x, 316);
        check("right_dir", direction, 3);
        check("right_state", state, 1);
        idle_cycle();
        check("nontick_hold_x", pos_x, 316);

        // up and left together: up wins.
        right = 1'b0; up = 1'b1; left = 1'b1;
        do_tick(1);
        check("arb_pos_y", pos_y, 444);
        check("arb_pos_x", pos_x, 316);
        check("arb_dir", direction, 0);

        // No direction: facing holds, state goes idle.
        up = 1'b0; left = 1'b0;
        do_tick(1);
        check("idle_state", state, 0);
        check("idle_dir", direction, 0);

        // Top clamp: 444 -> 3 -> 2 -> 0.
        up = 1'b1; speed = 3'd7;
        do_tick(63);
        speed = 3'd1;
        do_tick(1);
        check("pre_clamp_y", pos_y, 2);
        speed = 3'd5;
        do_tick(1);
        check("clamp_top", pos_y, 0);
        do_tick(1);
        check("clamp_top_again", pos_y, 0);

        // Right clamp: 316 -> 603 -> 605 -> 608.
        up = 1'b0; right = 1'b1; speed = 3'd7;
        do_tick(41);
        speed = 3'd2;
        do_tick(1);
        check("pre_clamp_x", pos_x, 605);
        speed = 3'd7;
        do_tick(1);
        check("clamp_right", pos_x, 608);
        do_tick(1);
        check("clamp_right_again", pos_x, 608);

        // Bottom edge: 0 + 7*64 lands exactly on 448, then stays there.
        right = 1'b0; down = 1'b1;
        do_tick(64);
        check("bottom_exact", pos_y, 448);
        do_tick(1);
        check("clamp_bottom", pos_y, 448);

        // Zero speed: facing updates, position holds.
        down = 1'b0; left = 1'b1; speed = 3'd0;
        do_tick(1);
        check("speed0_dir", direction, 2);
        check("speed0_x", pos_x, 608);

        // Fire held for ten ticks; there is an idle cycle after each tick.
        left = 1'b0; fire = 1'b1;
        for (int k = 0; k < 10; k++) begin
            do_tick(1);
            check($sformatf("fire_pulse_t%0d", k + 1), fire_pulse, exp_pulse[k]);
            check($sformatf("fire_ready_t%0d", k + 1), ready, exp_ready[k]);
            check($sformatf("fire_state_t%0d", k + 1), state, exp_state[k]);
            idle_cycle();
            check($sformatf("nontick_pulse_t%0d", k + 1), fire_pulse, 0);
            check($sformatf("nontick_ready_t%0d", k + 1), ready, exp_ready[k]);
        end

        // Drain the cooldown (2 left), then fire, then reset mid-cooldown.
        fire = 1'b0;
        do_tick(2);
        check("drained_ready", ready, 1);
        check("drained_state", state, 0);
        fire = 1'b1;
        do_tick(1);
        check("mid_fire_pulse", fire_pulse, 1);
        check("mid_fire_ready", ready, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_state", state, 0);
        check("mid_rst_pulse", fire_pulse, 0);
        check("mid_rst_x", pos_x, 304);
        check("mid_rst_dir", direction, 0);
        rst = 1'b0;
        #1;
        // First tick after reset fires and moves left; the shot carries the new facing.
        speed = 3'd4; left = 1'b1;
        do_tick(1);
        check("post_rst_pulse", fire_pulse, 1);
        check("post_rst_ready", ready, 0);
        check("post_rst_state", state, 2);
        check("post_rst_dir", direction, 2);
        check("post_rst_x", pos_x, 300);
        fire = 1'b0; left = 1'b0;
        do_tick(1);
        check("post_rst_pulse_end", fire_pulse, 0);

`ifdef TANK_OBSTACLE_STOP_EN
        // The cooldown is at 2 here. Up moves to 444, then the blocked down tick drains it to 0.
        up = 1'b1;
        do_tick(1);
        check("obs_pre_y", pos_y, 444);
        up = 1'b0; down = 1'b1; blocked = 1'b1;
        do_tick(1);
        check("blocked_y", pos_y, 444);
        check("blocked_dir", direction, 1);
        check("blocked_state", state, 1);
        blocked = 1'b0;
        do_tick(1);
        check("unblocked_y", pos_y, 448);
        down = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
